tug_score_keeper: RTL and testbench
===================================

Name: tug_score_keeper

Overview:
- Match scoreboard at the output end of the tug-of-war playfield.
- Consumes the per-round win indications produced by the playfield's victory logic.
- Keeps a per-player score, shows both scores on two seven-segment digits, and issues the restartGame pulse that re-centres the lights for the next round.
- Declares a match winner at MAX_SCORE and then locks until reset.

Parameters:
- MAX_SCORE, 7: round wins needed to take the match. Legal range 1..9.
- HOLDOFF_CYCLES, 4: cycles the winning display is held before restartGame fires. Must be >= 1.

Ports:
- Clock  input  1  game clock (divided clock domain)
- Reset  input  1  asynchronous, active-low reset (0 = reset)
- left_win  input  1  level; high while the left player has won the current round
- right_win  input  1  level; high while the right player has won the current round
- left_score  output  4  left player round count, 0..MAX_SCORE
- right_score  output  4  right player round count, 0..MAX_SCORE
- HEX_L  output  7  active-low seven-segment digit of left_score, bit order gfedcba
- HEX_R  output  7  active-low seven-segment digit of right_score, bit order gfedcba
- restartGame  output  1  one-cycle pulse; clears the playfield for the next round
- match_over  output  1  high once either score reaches MAX_SCORE
- match_winner  output  1  1 = left player won the match, 0 = right; valid only when match_over = 1

Behaviour:
- Reset (Reset = 0, asynchronous):
  - state = PLAY, both scores = 0, edge registers = 0, holdoff counter = 0.
  - restartGame = 0, match_over = 0, match_winner = 0.
  - HEX_L = HEX_R = 7'b1000000 (digit 0).
  - Reset asserted mid-round or mid-holdoff aborts immediately; no restartGame pulse is emitted.
- Edge detection:
  - left_prev and right_prev register left_win and right_win every cycle, in every state.
  - rise_L = left_win & ~left_prev; rise_R = right_win & ~right_prev.
  - A win level held high across restart or holdoff therefore never re-scores.
- State machine (PLAY, HOLDOFF, RESTART, MATCH_OVER):
  - PLAY, rise_L only: left_score += 1 at that same clock edge. If the new value equals MAX_SCORE, go to MATCH_OVER and set match_winner = 1; otherwise go to HOLDOFF and load the counter with HOLDOFF_CYCLES-1.
  - PLAY, rise_R only: symmetric. At MAX_SCORE, match_winner = 0.
  - PLAY, rise_L and rise_R in the same cycle: tie. No score change; go to HOLDOFF (round replayed).
  - PLAY, no rise: stay in PLAY.
  - HOLDOFF: the counter decrements each cycle. When the counter = 0, go to RESTART. All win edges are ignored.
  - RESTART: restartGame = 1 for exactly this one cycle, then return to PLAY. Win edges are ignored.
  - MATCH_OVER: match_over = 1. restartGame stays 0. Scores are frozen and inputs are ignored until Reset.
- Timing: with a rise sampled at edge k, the score is visible after edge k, and restartGame is high during the cycle after edge k+HOLDOFF_CYCLES.
- Arithmetic: 4-bit scores that never exceed MAX_SCORE, so no wrap-around is possible.
- Display: HEX_L and HEX_R are combinational decodes of the registered scores, so they update in the same cycle as the score. Active-low encoding:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other value = 1111111 (blank). This is unreachable.
- All outputs except the HEX decodes are registered.

Test Plan:
1. Reset low then high; drive no inputs -> scores 0, HEX_L = HEX_R = 1000000, restartGame = 0, match_over = 0 throughout.
2. left_win rises and is held high for 20 cycles (HOLDOFF_CYCLES = 4) -> left_score = 1 after the first edge. HEX_L = 1111001. A single restartGame pulse appears exactly 4 cycles later, and there is no second increment while the input is held.
3. left_win and right_win rise on the same cycle -> both scores unchanged. A single restartGame pulse appears after the holdoff.
4. Seven separate right_win rises, each after the prior restart (MAX_SCORE = 7) -> right_score = 7, HEX_R = 1111000, match_over = 1, match_winner = 0. No restartGame after the 7th win, and further left/right rises leave the scores frozen.
5. Reset driven low 2 cycles into a HOLDOFF -> all outputs return to reset values immediately, and restartGame never pulses.
6. right_win rises during HOLDOFF, and left_win rises one cycle after RESTART -> the right edge is ignored and left_score increments by exactly 1.

Source files
------------

// File: rtl/tug_score_keeper.sv
// ---------------------------------------------------------------------------
// tug_score_keeper
//   Match scoreboard for the tug-of-war playfield. Turns the per-round win
//   levels into score increments (rising edge only), shows both scores on
//   active-low seven-segment digits, fires restartGame after a short holdoff
//   so the lights re-centre, and locks once either player reaches MAX_SCORE.
//
//   State table:
//     PLAY       | round in progress, waiting for a win edge
//     HOLDOFF    | winning display held, counting down before restart
//     RESTART    | restartGame asserted for this single cycle
//     MATCH_OVER | match decided, scores frozen until Reset
//
// Ports:
//   Clock        in   game clock
//   Reset        in   asynchronous active-low reset
//   left_win     in   level, left player has won the current round
//   right_win    in   level, right player has won the current round
//   left_score   out  left round count, 0..MAX_SCORE
//   right_score  out  right round count, 0..MAX_SCORE
//   HEX_L        out  active-low gfedcba digit of left_score
//   HEX_R        out  active-low gfedcba digit of right_score
//   restartGame  out  one-cycle playfield clear pulse
//   match_over   out  high once a player reaches MAX_SCORE
//   match_winner out  1 = left won the match, 0 = right (valid with match_over)
// ---------------------------------------------------------------------------
module tug_score_keeper #(
    parameter int MAX_SCORE      = 7,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       left_win,
    input  logic       right_win,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic [6:0] HEX_L,
    output logic [6:0] HEX_R,
    output logic       restartGame,
    output logic       match_over,
    output logic       match_winner
);

    localparam int               CNT_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       MAX_S    = 4'(MAX_SCORE);

    typedef enum logic [1:0] {
        S_PLAY       = 2'd0,
        S_HOLDOFF    = 2'd1,
        S_RESTART    = 2'd2,
        S_MATCH_OVER = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       left_q, left_d;
    logic [3:0]       right_q, right_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             winner_q, winner_d;
    logic             restart_q, restart_d;
    logic             over_q, over_d;
    logic             left_prev_q, right_prev_q;
    logic             rise_l, rise_r;

    assign rise_l = left_win  & ~left_prev_q;
    assign rise_r = right_win & ~right_prev_q;

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        right_d  = right_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        case (state_q)
            S_PLAY: begin
                if (rise_l && rise_r) begin
                    // Tie: round is replayed without touching the scores.
                    state_d = S_HOLDOFF;
                    cnt_d   = CNT_LOAD;
                end else if (rise_l) begin
                    left_d = left_q + 4'd1;
                    if (left_d == MAX_S) begin
                        state_d  = S_MATCH_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = CNT_LOAD;
                    end
                end else if (rise_r) begin
                    right_d = right_q + 4'd1;
                    if (right_d == MAX_S) begin
                        state_d  = S_MATCH_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = S_RESTART;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RESTART:    state_d = S_PLAY;
            S_MATCH_OVER: state_d = S_MATCH_OVER;
            default:      state_d = S_PLAY;
        endcase
    end

    // Registered flags follow the state being entered, so restartGame is high
    // exactly while the FSM sits in RESTART and match_over while in MATCH_OVER.
    assign restart_d = (state_d == S_RESTART);
    assign over_d    = (state_d == S_MATCH_OVER);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= S_PLAY;
            left_q       <= 4'd0;
            right_q      <= 4'd0;
            cnt_q        <= '0;
            winner_q     <= 1'b0;
            restart_q    <= 1'b0;
            over_q       <= 1'b0;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            left_q       <= left_d;
            right_q      <= right_d;
            cnt_q        <= cnt_d;
            winner_q     <= winner_d;
            restart_q    <= restart_d;
            over_q       <= over_d;
            left_prev_q  <= left_win;
            right_prev_q <= right_win;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign left_score   = left_q;
    assign right_score  = right_q;
    assign HEX_L        = seg7(left_q);
    assign HEX_R        = seg7(right_q);
    assign restartGame  = restart_q;
    assign match_over   = over_q;
    assign match_winner = winner_q;

endmodule

// File: tb/tb_tug_score_keeper.sv
module tb_tug_score_keeper;

    localparam int MAX  = 7;
    localparam int HOLD = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       left_win = 1'b0;
    logic       right_win = 1'b0;
    logic [3:0] left_score, right_score;
    logic [6:0] HEX_L, HEX_R;
    logic       restartGame, match_over, match_winner;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_l  = 0;
    int exp_r  = 0;
    int restart_q[$];

    tug_score_keeper #(.MAX_SCORE(MAX), .HOLDOFF_CYCLES(HOLD)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .left_win     (left_win),
        .right_win    (right_win),
        .left_score   (left_score),
        .right_score  (right_score),
        .HEX_L        (HEX_L),
        .HEX_R        (HEX_R),
        .restartGame  (restartGame),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [6:0] hex_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Scoreboard side: every restartGame pulse must match the next expected cycle.
    always @(negedge Clock) begin
        if (restart_q.size() != 0 && restart_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL restart_missing expected_cyc=%0d now=%0d", restart_q[0], cyc);
            void'(restart_q.pop_front());
        end
        if (restartGame === 1'b1) begin
            checks++;
            if (restart_q.size() == 0) begin
                errors++;
                $display("FAIL restart_unexpected cyc=%0d actual=1 required=0", cyc);
            end else begin
                int e;
                e = restart_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL restart_timing actual_cyc=%0d required_cyc=%0d", cyc, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic check_scores(input string tag);
        checks++;
        if (left_score !== 4'(exp_l) || right_score !== 4'(exp_r) ||
            HEX_L !== hex_of(exp_l) || HEX_R !== hex_of(exp_r)) begin
            errors++;
            $display("FAIL %s scores actual L=%0d R=%0d HL=%b HR=%b required L=%0d R=%0d HL=%b HR=%b",
                     tag, left_score, right_score, HEX_L, HEX_R, exp_l, exp_r,
                     hex_of(exp_l), hex_of(exp_r));
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        tick(3);
        Reset = 1'b1;
        exp_l = 0;
        exp_r = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_scores("reset");
            checks++;
            if (restartGame !== 1'b0 || match_over !== 1'b0 || match_winner !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags actual r=%b o=%b w=%b required 0 0 0",
                         restartGame, match_over, match_winner);
            end
        end
    endtask

    task automatic test_single_left;
        left_win = 1'b1;
        restart_q.push_back(cyc + 1 + HOLD);
        exp_l++;
        tick(1);
        check_scores("left_first");
        tick(19);
        check_scores("left_held");
        left_win = 1'b0;
        tick(2);
    endtask

    task automatic test_tie;
        left_win  = 1'b1;
        right_win = 1'b1;
        restart_q.push_back(cyc + 1 + HOLD);
        tick(1);
        check_scores("tie");
        tick(HOLD + 3);
        check_scores("tie_after");
        left_win  = 1'b0;
        right_win = 1'b0;
        tick(2);
    endtask

    task automatic test_back_to_back;
        int c;
        c = cyc;
        left_win = 1'b1;
        restart_q.push_back(c + 1 + HOLD);
        exp_l++;
        tick(1);
        check_scores("b2b_first");
        left_win = 1'b0;
        tick(1);
        right_win = 1'b1;              // sampled while in HOLDOFF
        while (cyc < c + 6) tick(1);   // first PLAY cycle after RESTART
        check_scores("b2b_right_ignored");
        left_win = 1'b1;
        restart_q.push_back(cyc + 1 + HOLD);
        exp_l++;
        tick(1);
        check_scores("b2b_left_again");
        tick(HOLD + 3);
        check_scores("b2b_after");
        left_win  = 1'b0;
        right_win = 1'b0;
        tick(2);
    endtask

    task automatic test_match;
        for (int i = 0; i < MAX; i++) begin
            right_win = 1'b1;
            exp_r++;
            if (exp_r < MAX) restart_q.push_back(cyc + 1 + HOLD);
            tick(1);
            check_scores("match_step");
            tick(HOLD + 2);
            right_win = 1'b0;
            tick(1);
        end
        checks++;
        if (match_over !== 1'b1 || match_winner !== 1'b0 || HEX_R !== 7'b1111000) begin
            errors++;
            $display("FAIL match_end actual o=%b w=%b HR=%b required 1 0 1111000",
                     match_over, match_winner, HEX_R);
        end
        left_win  = 1'b1;
        right_win = 1'b1;
        tick(HOLD + 4);
        left_win  = 1'b0;
        right_win = 1'b0;
        tick(2);
        right_win = 1'b1;
        tick(HOLD + 4);
        right_win = 1'b0;
        check_scores("match_frozen");
        checks++;
        if (match_over !== 1'b1 || match_winner !== 1'b0) begin
            errors++;
            $display("FAIL match_locked actual o=%b w=%b required 1 0", match_over, match_winner);
        end
    endtask

    task automatic test_reset_holdoff;
        Reset = 1'b0;
        tick(2);
        Reset = 1'b1;
        exp_l = 0;
        exp_r = 0;
        tick(2);
        left_win = 1'b1;               // no restart expected: reset aborts holdoff
        tick(1);
        exp_l = 1;
        check_scores("rh_scored");
        tick(2);
        left_win = 1'b0;
        Reset = 1'b0;
        #1;
        exp_l = 0;
        check_scores("rh_async");
        checks++;
        if (restartGame !== 1'b0 || match_over !== 1'b0 || match_winner !== 1'b0) begin
            errors++;
            $display("FAIL rh_flags actual r=%b o=%b w=%b required 0 0 0",
                     restartGame, match_over, match_winner);
        end
        tick(3);
        Reset = 1'b1;
        tick(HOLD + 4);
        check_scores("rh_after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tick(1);
        test_reset;
        test_single_left;
        test_tie;
        test_back_to_back;
        test_match;
        test_reset_holdoff;
        tick(2);
        checks++;
        if (restart_q.size() != 0) begin
            errors++;
            $display("FAIL restart_pending actual=%0d required=0", restart_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
